conv_scheduler: RTL and testbench

- Sequencing controller for the 5x5 convolution datapath (25 multipliers, adder tree, ReLU) of the LeNet-5 C1 layer.
- For each output feature map it loads 25 weights plus a bias from weight memory, then sweeps every 28x28 output position over the 32x32 input.
- It issues window requests to the input window buffer, tracks datapath pipeline latency and generates output-memory write strobes and addresses.

---
 rtl/conv_scheduler_pkg.sv | 24 ++
 rtl/conv_scheduler_if.sv | 32 +++
 rtl/conv_scheduler_valid_delay_line.sv | 31 +++
 rtl/conv_scheduler.sv | 118 +++++++++++
 tb/tb_conv_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_scheduler_pkg.sv
// Shared constants and state encoding for the C1 convolution scheduler.
// Later layer schedulers reuse the same derived-size pattern.
package conv_scheduler_pkg;
    localparam int FILTER_SIZE        = 5;
    localparam int INPUT_WIDTH        = 32;
    localparam int OUTPUT_WIDTH       = INPUT_WIDTH - FILTER_SIZE + 1;
    localparam int OUTPUT_FEATURE_MAP = 6;
    localparam int W_DEPTH            = 26;
    localparam int PIPE_LATENCY       = 7;
    localparam int OUT_ADDR_W         = 13;
    localparam int W_ADDR_W           = 8;

    localparam int OUT_MAP_SIZE = OUTPUT_WIDTH * OUTPUT_WIDTH;
    localparam int WIN_COUNT    = OUT_MAP_SIZE;  // one window per output pixel

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        RUN,
        DRAIN,
        NEXT,
        DONE
    } state_t;
endpackage

// File: rtl/conv_scheduler_if.sv
// Control/handshake bundle between the C1 scheduler and its memories,
// window buffer and datapath.
interface conv_scheduler_if;
    import conv_scheduler_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  w_rd_en;
    logic [W_ADDR_W-1:0]   w_rd_addr;
    logic                  w_load_en;
    logic [4:0]            w_load_idx;
    logic                  win_ready;
    logic                  win_valid;
    logic [4:0]            win_row;
    logic [4:0]            win_col;
    logic                  out_we;
    logic [OUT_ADDR_W-1:0] out_addr;
    logic [2:0]            map_idx;

    modport master (
        input  start, win_ready,
        output busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_idx,
               win_valid, win_row, win_col, out_we, out_addr, map_idx
    );

    modport slave (
        output start, win_ready,
        input  busy, done, w_rd_en, w_rd_addr, w_load_en, w_load_idx,
               win_valid, win_row, win_col, out_we, out_addr, map_idx
    );
endinterface

// File: rtl/conv_scheduler_valid_delay_line.sv
// {valid,addr} delay line matching the datapath latency; never stalls.
// pend flags items that will still be in flight after this cycle.
module valid_delay_line #(
    parameter int DEPTH = 7,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         pend
);
    logic [DEPTH-1:0]        vld_pipe;
    logic [DEPTH-1:0][W-1:0] dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], in_vld};
            dat_pipe <= {dat_pipe[DEPTH-2:0], in_dat};
        end
    end

    assign out_vld = vld_pipe[DEPTH-1];
    assign out_dat = dat_pipe[DEPTH-1];
    assign pend    = |vld_pipe[DEPTH-2:0];
endmodule

// File: rtl/conv_scheduler.sv
// LeNet-5 C1 sequencer: per map, loads 25 weights + bias, then sweeps all
// 28x28 windows and emits output writes PIPE_LATENCY cycles after issue.
module conv_scheduler
    import conv_scheduler_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    conv_scheduler_if.master bus
);
    state_t                state;
    logic [2:0]            map;
    logic [4:0]            row, col, rd_idx;
    logic [OUT_ADDR_W-1:0] obase;  // map*784 + row*28, accumulated
    logic                  xfer, pend;
    logic [OUT_ADDR_W-1:0] issue_addr;

    assign xfer        = bus.win_valid && bus.win_ready;
    assign issue_addr  = obase + OUT_ADDR_W'(col);
    assign bus.win_row = row;
    assign bus.win_col = col;
    assign bus.map_idx = map;

    valid_delay_line #(.DEPTH(PIPE_LATENCY), .W(OUT_ADDR_W)) u_vdl (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (xfer),
        .in_dat (issue_addr),
        .out_vld(bus.out_we),
        .out_dat(bus.out_addr),
        .pend   (pend)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            map            <= '0;
            row            <= '0;
            col            <= '0;
            rd_idx         <= '0;
            obase          <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.w_rd_en    <= 1'b0;
            bus.w_rd_addr  <= '0;
            bus.w_load_en  <= 1'b0;
            bus.w_load_idx <= '0;
            bus.win_valid  <= 1'b0;
        end else begin
            // Weight memory has one cycle of read latency.
            bus.w_load_en  <= bus.w_rd_en;
            bus.w_load_idx <= rd_idx;
            bus.done       <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state         <= LOAD_W;
                    bus.busy      <= 1'b1;
                    map           <= '0;
                    row           <= '0;
                    col           <= '0;
                    obase         <= '0;
                    rd_idx        <= '0;
                    bus.w_rd_en   <= 1'b1;
                    bus.w_rd_addr <= '0;
                end
                LOAD_W: begin
                    if (bus.w_rd_en) begin
                        if (rd_idx == 5'(W_DEPTH-1)) begin
                            bus.w_rd_en <= 1'b0;
                        end else begin
                            rd_idx        <= rd_idx + 5'd1;
                            bus.w_rd_addr <= bus.w_rd_addr + W_ADDR_W'(1);
                        end
                    end else begin
                        // bias capture is happening this cycle
                        state         <= RUN;
                        bus.win_valid <= 1'b1;
                    end
                end
                RUN: if (xfer) begin
                    if (col == 5'(OUTPUT_WIDTH-1)) begin
                        col <= '0;
                        if (row == 5'(OUTPUT_WIDTH-1)) begin
                            state         <= DRAIN;
                            bus.win_valid <= 1'b0;
                        end else begin
                            row   <= row + 5'd1;
                            obase <= obase + OUT_ADDR_W'(OUTPUT_WIDTH);
                        end
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                // Leave once only the tail (written this cycle) can still be valid.
                DRAIN: if (!pend) state <= NEXT;
                NEXT: begin
                    if (map == 3'(OUTPUT_FEATURE_MAP-1)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state         <= LOAD_W;
                        map           <= map + 3'd1;
                        row           <= '0;
                        col           <= '0;
                        obase         <= obase + OUT_ADDR_W'(OUTPUT_WIDTH);
                        rd_idx        <= '0;
                        bus.w_rd_en   <= 1'b1;
                        bus.w_rd_addr <= bus.w_rd_addr + W_ADDR_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: reset, full layers with free-running
// and stalling window buffer, ignored start, async abort.
module tb_conv_scheduler;
    import conv_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mon_clr = 1'b1;

    conv_scheduler_if bus();

    conv_scheduler dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, sampled on the falling edge.
    wire xfer_t = bus.win_valid && bus.win_ready;
    int cyc = 0;
    int wr_cnt, exp_addr, last_addr, seq_err, first_x, first_w;
    int pos_err, er, ec, b_r, b_c, drain_err, hold_err, stall_cnt, pr, pc;
    int gap_err, rd_cnt, rd_err, m5_min, m5_max, ld_err, ldi_err, ld_cnt;
    int bias_loads, ord_w, ord_l, done_cnt;
    bit after027, last_flag, prev_stall, prev_rd_en;
    bit [7:1] h;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr || !rst_n) begin
            wr_cnt <= 0; exp_addr <= 0; last_addr <= -1; seq_err <= 0;
            first_x <= -1; first_w <= -1; pos_err <= 0; er <= 0; ec <= 0;
            b_r <= -1; b_c <= -1; drain_err <= 0; hold_err <= 0; stall_cnt <= 0;
            pr <= 0; pc <= 0; gap_err <= 0; rd_cnt <= 0; rd_err <= 0;
            m5_min <= 9999; m5_max <= -1; ld_err <= 0; ldi_err <= 0; ld_cnt <= 0;
            bias_loads <= 0; ord_w <= 0; ord_l <= 0; done_cnt <= 0;
            after027 <= 0; last_flag <= 0; prev_stall <= 0; prev_rd_en <= 0; h <= '0;
        end else begin
            if (bus.out_we != h[7]) gap_err <= gap_err + 1;
            if (bus.out_we) begin
                if (first_w < 0) first_w <= cyc;
                if (int'(bus.out_addr) != exp_addr) seq_err <= seq_err + 1;
                if (int'(bus.out_addr) / OUT_MAP_SIZE >= bias_loads) ord_w <= ord_w + 1;
                exp_addr  <= exp_addr + 1;
                wr_cnt    <= wr_cnt + 1;
                last_addr <= int'(bus.out_addr);
            end
            if (last_flag && bus.win_valid) drain_err <= drain_err + 1;
            last_flag <= xfer_t && bus.win_row == 27 && bus.win_col == 27;
            if (prev_stall && (bus.win_row != pr || bus.win_col != pc)) hold_err <= hold_err + 1;
            if (bus.win_valid && !bus.win_ready) stall_cnt <= stall_cnt + 1;
            if (xfer_t) begin
                if (first_x < 0) first_x <= cyc;
                if (int'(bus.win_row) != er || int'(bus.win_col) != ec) pos_err <= pos_err + 1;
                if (after027) begin
                    b_r <= int'(bus.win_row);
                    b_c <= int'(bus.win_col);
                end
                after027 <= (b_r < 0 && !after027 && bus.win_row == 0 && bus.win_col == 27);
                if (ec == 27) begin
                    ec <= 0;
                    er <= (er == 27) ? 0 : er + 1;
                end else begin
                    ec <= ec + 1;
                end
            end
            prev_stall <= bus.win_valid && !bus.win_ready;
            pr <= int'(bus.win_row);
            pc <= int'(bus.win_col);
            if (bus.w_load_en != prev_rd_en) ld_err <= ld_err + 1;
            if (bus.w_load_en) begin
                if (int'(bus.w_load_idx) != ld_cnt % W_DEPTH) ldi_err <= ldi_err + 1;
                if (wr_cnt != int'(bus.map_idx) * OUT_MAP_SIZE) ord_l <= ord_l + 1;
                if (bus.w_load_idx == 25) bias_loads <= bias_loads + 1;
                ld_cnt <= ld_cnt + 1;
            end
            if (bus.w_rd_en) begin
                if (int'(bus.w_rd_addr) != rd_cnt) rd_err <= rd_err + 1;
                rd_cnt <= rd_cnt + 1;
                if (bus.map_idx == 5) begin
                    if (int'(bus.w_rd_addr) < m5_min) m5_min <= int'(bus.w_rd_addr);
                    if (int'(bus.w_rd_addr) > m5_max) m5_max <= int'(bus.w_rd_addr);
                end
            end
            prev_rd_en <= bus.w_rd_en;
            if (bus.done) done_cnt <= done_cnt + 1;
            h <= {h[6:1], xfer_t};
        end
    end

    task automatic wait_layer(input string tag, input bit tog);
        int  i;
        bit  pulsed;
        pulsed = 0;
        for (i = 0; i < 20000; i++) begin
            step();
            if (tog && bus.busy && bus.map_idx == 0) bus.win_ready = ~bus.win_ready;
            else bus.win_ready = 1'b1;
            if (tog && !pulsed && bus.map_idx == 1 && bus.win_valid) begin
                bus.start = 1'b1;
                pulsed = 1;
            end else begin
                bus.start = 1'b0;
            end
            if (done_cnt > 0 && !bus.busy) break;
        end
        chk({tag, "_finished"}, i < 20000, 1);
        repeat (20) step();
    endtask

    initial begin
        int i;
        bus.start = 1'b0;
        bus.win_ready = 1'b1;
        repeat (2) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_w_rd_en", bus.w_rd_en, 0);
        chk("rst_w_load_en", bus.w_load_en, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_out_we", bus.out_we, 0);
        chk("rst_w_rd_addr", bus.w_rd_addr, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        rst_n = 1'b1;
        step();
        mon_clr = 1'b0;
        step();

        // Layer A: window buffer always ready.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("L0_rd_en", bus.w_rd_en, 1);
        chk("L0_rd_addr", bus.w_rd_addr, 0);
        chk("L0_busy", bus.busy, 1);
        chk("L0_ld_en", bus.w_load_en, 0);
        step();
        chk("L1_ld_en", bus.w_load_en, 1);
        chk("L1_ld_idx", bus.w_load_idx, 0);
        chk("L1_rd_addr", bus.w_rd_addr, 1);
        repeat (24) step();
        chk("L25_rd_addr", bus.w_rd_addr, 25);
        chk("L25_ld_idx", bus.w_load_idx, 24);
        step();
        chk("L26_rd_en", bus.w_rd_en, 0);
        chk("L26_ld_en", bus.w_load_en, 1);
        chk("L26_ld_idx", bus.w_load_idx, 25);
        chk("L26_win_valid", bus.win_valid, 0);
        step();
        chk("R0_win_valid", bus.win_valid, 1);
        chk("R0_row", bus.win_row, 0);
        chk("R0_col", bus.win_col, 0);
        wait_layer("A", 0);
        chk("A_writes", wr_cnt, 4704);
        chk("A_last_addr", last_addr, 4703);
        chk("A_seq_err", seq_err, 0);
        chk("A_latency", first_w - first_x, 7);
        chk("A_pos_err", pos_err, 0);
        chk("A_gap_err", gap_err, 0);
        chk("A_rd_err", rd_err, 0);
        chk("A_rd_cnt", rd_cnt, 156);
        chk("A_ld_err", ld_err, 0);
        chk("A_ldi_err", ldi_err, 0);
        chk("A_m5_rd_min", m5_min, 130);
        chk("A_m5_rd_max", m5_max, 155);
        chk("A_order_wr", ord_w, 0);
        chk("A_order_ld", ord_l, 0);
        chk("A_after_0_27_row", b_r, 1);
        chk("A_after_0_27_col", b_c, 0);
        chk("A_drain_valid", drain_err, 0);
        chk("A_done_cnt", done_cnt, 1);
        chk("A_busy_end", bus.busy, 0);

        // Layer B: ready toggles during map 0, stray start during map 1.
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_layer("B", 1);
        chk("B_stalled", stall_cnt > 500, 1);
        chk("B_hold_err", hold_err, 0);
        chk("B_gap_err", gap_err, 0);
        chk("B_seq_err", seq_err, 0);
        chk("B_pos_err", pos_err, 0);
        chk("B_writes", wr_cnt, 4704);
        chk("B_last_addr", last_addr, 4703);
        chk("B_order_ld", ord_l, 0);
        chk("B_drain_valid", drain_err, 0);
        chk("B_done_cnt", done_cnt, 1);
        chk("B_busy_end", bus.busy, 0);

        // Layer C: async abort in the middle of map 2.
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (i = 0; i < 20000; i++) begin
            step();
            if (bus.map_idx == 2 && bus.win_valid && bus.win_row == 10) break;
        end
        chk("C_reached_map2", i < 20000, 1);
        chk("C_pre_out_we", bus.out_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("C_busy", bus.busy, 0);
        chk("C_win_valid", bus.win_valid, 0);
        chk("C_out_we", bus.out_we, 0);
        chk("C_out_addr", bus.out_addr, 0);
        chk("C_w_rd_en", bus.w_rd_en, 0);
        chk("C_w_rd_addr", bus.w_rd_addr, 0);
        chk("C_map_idx", bus.map_idx, 0);
        chk("C_win_row", bus.win_row, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (200) step();
        chk("C_no_writes", wr_cnt, 0);
        chk("C_no_done", done_cnt, 0);
        chk("C_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
